// File: rtl/sorted_cam_pkg.sv
// Shared state encoding, default widths and request record for the sorted-CAM update scheduler.
package sorted_cam_pkg;

  localparam int ADDR_SIZE = 22;
  localparam int CNT_SIZE  = 32;
  localparam int STAT_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [CNT_SIZE-1:0]  cnt;
  } req_t;

endpackage

// File: rtl/sorted_cam_sched_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above i_ptr, wrapping.
// Zero latency; grants nothing while i_en is low.
module rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_SIZE = 2
) (
  input  logic [NUM_REQ-1:0]      i_valid,
  input  logic [REQ_IDX_SIZE-1:0] i_ptr,
  input  logic                    i_en,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [REQ_IDX_SIZE-1:0] o_grant_idx,
  output logic                    o_any
);

  localparam int SUM_W = REQ_IDX_SIZE + 1;

  logic [SUM_W-1:0]        w_sum;
  logic [REQ_IDX_SIZE-1:0] w_idx;

  // Candidate index is ptr+k folded back below NUM_REQ; the first hit wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      w_idx = w_sum[REQ_IDX_SIZE-1:0];
      if (i_en && !o_any && i_valid[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/sorted_cam_sched.sv
// Round-robin pacer for the sorted-CAM update port: transfer at t gives a 1-cycle cam_input_valid at t+1, then a gap cycle.
// req_ready is combinational and one-hot, offered only in IDLE/GAP with enable; SORTED_CAM_SCHED_FILTER_EN drops counts <= cam_min_cnt.
module sorted_cam_sched #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_SIZE = 2,
  parameter int ADDR_SIZE    = 22,
  parameter int CNT_SIZE     = 32,
  parameter int STAT_SIZE    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]  req_addr,
  input  logic [NUM_REQ*CNT_SIZE-1:0]   req_cnt,
  output logic                          cam_input_valid,
  output logic [ADDR_SIZE-1:0]          cam_input_addr,
  output logic [CNT_SIZE-1:0]           cam_input_cnt,
  input  logic [CNT_SIZE-1:0]           cam_min_cnt,
  output logic [REQ_IDX_SIZE-1:0]       grant_id,
  output logic                          busy,
  output logic [STAT_SIZE-1:0]          issue_count,
  output logic [STAT_SIZE-1:0]          drop_count
);

  import sorted_cam_pkg::*;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [REQ_IDX_SIZE-1:0] r_ptr;
  logic [REQ_IDX_SIZE-1:0] r_grant_id;
  logic [REQ_IDX_SIZE-1:0] w_grant_idx;
  logic [REQ_IDX_SIZE-1:0] w_ptr_nxt;
  logic [NUM_REQ-1:0]      w_grant;
  logic                    w_window;
  logic                    w_xfer;
  logic                    w_drop;
  req_t                    w_sel;
  req_t                    r_hold;
  logic                    r_cam_valid;
  logic [STAT_SIZE-1:0]    r_issue_count;

  // The CAM only samples a new update outside its request state, hence ISSUE is never a window.
  assign w_window = enable && ((r_state == IDLE) || (r_state == GAP));

  rr_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .REQ_IDX_SIZE (REQ_IDX_SIZE)
  ) u_arb (
    .i_valid     (req_valid),
    .i_ptr       (r_ptr),
    .i_en        (w_window),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_xfer)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_sel = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_grant[r]) begin
        w_sel.addr = req_addr[r*ADDR_SIZE +: ADDR_SIZE];
        w_sel.cnt  = req_cnt[r*CNT_SIZE +: CNT_SIZE];
      end
    end
  end

  assign w_ptr_nxt = (w_grant_idx == REQ_IDX_SIZE'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, GAP: w_state_nxt = (w_xfer && !w_drop) ? ISSUE : IDLE;
      ISSUE:     w_state_nxt = GAP;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_hold        <= '0;
      r_cam_valid   <= 1'b0;
      r_issue_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cam_valid <= (w_state_nxt == ISSUE);
      if (w_xfer) begin
        r_ptr      <= w_ptr_nxt;
        r_grant_id <= w_grant_idx;
        r_hold     <= w_sel;
      end
      // Counted as the pulse is launched so the count moves together with cam_input_valid.
      if (w_xfer && !w_drop && (r_issue_count != '1)) begin
        r_issue_count <= r_issue_count + 1'b1;
      end
    end
  end

`ifdef SORTED_CAM_SCHED_FILTER_EN
  logic [STAT_SIZE-1:0] r_drop_count;

  assign w_drop = w_xfer && (w_sel.cnt <= cam_min_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign drop_count = r_drop_count;
`else
  logic w_unused_min_cnt;

  assign w_unused_min_cnt = ^cam_min_cnt;
  assign w_drop           = 1'b0;
  assign drop_count       = '0;
`endif

  assign cam_input_valid = r_cam_valid;
  assign cam_input_addr  = r_hold.addr;
  assign cam_input_cnt   = r_hold.cnt;
  assign grant_id        = r_grant_id;
  assign busy            = (r_state != IDLE);
  assign issue_count     = r_issue_count;

endmodule
